// File: rtl/fc_neuron_stream.sv
// Time-multiplexed signed fully-connected neuron with a writable weight file and a valid/ready result port.
// Optional build macro FC_RELU_EN clamps negative results to zero at the output stage.
module fc_neuron_stream #(
    parameter int WIDTH = 8,
    parameter int IN    = 128,
    parameter int LANES = 4,
    parameter int ACCW  = WIDTH*2+$clog2(IN)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [LANES*WIDTH-1:0]   s_data,
    input  logic                     w_we,
    input  logic [$clog2(IN)-1:0]    w_addr,
    input  logic [WIDTH-1:0]         w_data,
    output logic                     w_err,
    input  logic [ACCW-1:0]          bias,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [ACCW-1:0]          m_data
);
    localparam int BEATS = IN / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int AW    = $clog2(IN);
    localparam int PW    = 2*WIDTH;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS-1);

    localparam logic [1:0] ST_ACC   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_OUT   = 2'd2;

    logic [1:0]              r_state;
    logic [BW-1:0]           r_beat_cnt;
    logic [ACCW-1:0]         r_acc;
    logic signed [PW-1:0]    r_prod [LANES];
    logic                    r_prod_vld;
    logic                    r_m_valid;
    logic [ACCW-1:0]         r_m_data;
    logic                    r_w_err;
    logic signed [WIDTH-1:0] r_w [IN];

    logic                    w_hs;
    logic                    w_addr_ok;
    logic                    w_wr_ok;
    logic [AW-1:0]           w_idx  [LANES];
    logic signed [PW-1:0]    w_prod [LANES];
    logic [ACCW-1:0]         w_psum;
    logic [ACCW-1:0]         w_sum;
    logic [ACCW-1:0]         w_out;

    assign s_ready = (r_state == ST_ACC);
    assign w_hs    = s_valid && s_ready;
    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign w_err   = r_w_err;

    // Out-of-range addresses only exist when IN is not a power of two.
    if ((2**AW) > IN) begin : g_addr_chk
        assign w_addr_ok = (w_addr < AW'(IN));
    end else begin : g_addr_full
        assign w_addr_ok = 1'b1;
    end

    // Weights may only change between vectors so a vector never sees a mix of old and new weights.
    assign w_wr_ok = w_we && w_addr_ok && (r_state == ST_ACC) &&
                     (r_beat_cnt == '0) && !w_hs;

    // Per-lane signed products against the weight slice selected by the beat counter.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            w_idx[k]  = AW'(int'(r_beat_cnt) * LANES + k);
            w_prod[k] = PW'($signed(s_data[k*WIDTH +: WIDTH])) * PW'(r_w[w_idx[k]]);
        end
    end

    // Adder tree over the registered products, sign-extended to the accumulator width.
    always_comb begin
        w_psum = '0;
        for (int k = 0; k < LANES; k++) begin
            w_psum = w_psum + ACCW'(r_prod[k]);
        end
    end

    // Final biased sum and output stage.
    always_comb begin
        w_sum = r_acc + w_psum + bias;
`ifdef FC_RELU_EN
        if (w_sum[ACCW-1]) begin
            w_out = '0;
        end else begin
            w_out = w_sum;
        end
`else
        w_out = w_sum;
`endif
    end

    // Weight register file; intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_w[w_addr] <= w_data;
        end
    end

    // Control FSM, product pipeline, accumulator and result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_ACC;
            r_beat_cnt <= '0;
            r_acc      <= '0;
            r_prod_vld <= 1'b0;
            r_m_valid  <= 1'b0;
            r_m_data   <= '0;
            r_w_err    <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                r_prod[k] <= '0;
            end
        end else begin
            r_w_err <= w_we && !w_wr_ok;
            case (r_state)
                ST_ACC: begin
                    r_prod_vld <= w_hs;
                    if (r_prod_vld) begin
                        r_acc <= r_acc + w_psum;
                    end
                    if (w_hs) begin
                        r_prod <= w_prod;
                        if (r_beat_cnt == LAST_BEAT) begin
                            r_beat_cnt <= '0;
                            r_state    <= ST_DRAIN;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + BW'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    // The last beat's products are folded in here rather than through the accumulator.
                    r_m_data   <= w_out;
                    r_m_valid  <= 1'b1;
                    r_acc      <= '0;
                    r_prod_vld <= 1'b0;
                    r_state    <= ST_OUT;
                end
                ST_OUT: begin
                    if (m_ready) begin
                        r_m_valid <= 1'b0;
                        r_state   <= ST_ACC;
                    end
                end
                default: begin
                    r_state    <= ST_ACC;
                    r_prod_vld <= 1'b0;
                    r_m_valid  <= 1'b0;
                end
            endcase
        end
    end
endmodule
